// File: rtl/alu_issue_stage_if.sv
// ID/EX issue-stage bus: upstream entry, forwarding taps, ALU-side head.
// slave = the issue stage, master = whoever drives and consumes it.
interface alu_issue_stage_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 4,
  parameter int RAW  = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic [RAW-1:0]  in_rs1_addr;
  logic [RAW-1:0]  in_rs2_addr;
  logic [RAW-1:0]  in_rd_addr;
  logic [OPW-1:0]  in_aluop;
  logic            fwd_mem_valid;
  logic [RAW-1:0]  fwd_mem_rd;
  logic [XLEN-1:0] fwd_mem_data;
  logic            fwd_wb_valid;
  logic [RAW-1:0]  fwd_wb_rd;
  logic [XLEN-1:0] fwd_wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_X;
  logic [XLEN-1:0] alu_Y;
  logic [OPW-1:0]  alu_S;
  logic [RAW-1:0]  out_rd_addr;
  logic            out_div0;

  modport slave (
    input  flush, in_valid, in_rs1_val, in_rs2_val, in_imm,
    input  in_use_imm, in_rs1_addr, in_rs2_addr, in_rd_addr,
    input  in_aluop, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
    input  fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
    output in_ready, out_valid, alu_X, alu_Y, alu_S,
    output out_rd_addr, out_div0
  );

  modport master (
    output flush, in_valid, in_rs1_val, in_rs2_val, in_imm,
    output in_use_imm, in_rs1_addr, in_rs2_addr, in_rd_addr,
    output in_aluop, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
    output fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
    input  in_ready, out_valid, alu_X, alu_Y, alu_S,
    input  out_rd_addr, out_div0
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: forwards operands at capture, 2-entry skid to the ALU.
// Ports: clk, rst (async high), bus (alu_issue_stage_if.slave).
// ALU_ISSUE_DIV0_EN: enables the registered out_div0 flag.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 4,
  parameter int RAW  = 5
) (
  input logic              clk,
  input logic              rst,
  alu_issue_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [OPW-1:0]  s;
    logic [RAW-1:0]  rd;
    logic            div0;
  } ent_t;

  state_t state, nxt;
  ent_t   head, skid, inc;
  logic   vld, rdy;
  logic   acc, pop;
  logic   m1, w1, m2, w2;
  logic [XLEN-1:0] rs1, rs2;

  assign acc = bus.in_valid & rdy;
  assign pop = vld & bus.out_ready;

  // x0 is hardwired zero, so it never matches a forwarding tap.
  assign m1 = bus.fwd_mem_valid
            && bus.fwd_mem_rd == bus.in_rs1_addr
            && bus.in_rs1_addr != '0;
  assign w1 = bus.fwd_wb_valid
            && bus.fwd_wb_rd == bus.in_rs1_addr
            && bus.in_rs1_addr != '0;
  assign m2 = bus.fwd_mem_valid
            && bus.fwd_mem_rd == bus.in_rs2_addr
            && bus.in_rs2_addr != '0;
  assign w2 = bus.fwd_wb_valid
            && bus.fwd_wb_rd == bus.in_rs2_addr
            && bus.in_rs2_addr != '0;

  // EX/MEM is younger than MEM/WB, so it wins.
  always_comb begin
    rs1 = bus.in_rs1_val;
    priority case (1'b1)
      m1:      rs1 = bus.fwd_mem_data;
      w1:      rs1 = bus.fwd_wb_data;
      default: rs1 = bus.in_rs1_val;
    endcase
  end

  always_comb begin
    rs2 = bus.in_rs2_val;
    priority case (1'b1)
      m2:      rs2 = bus.fwd_mem_data;
      w2:      rs2 = bus.fwd_wb_data;
      default: rs2 = bus.in_rs2_val;
    endcase
  end

  always_comb begin
    inc    = '0;
    inc.x  = rs1;
    inc.y  = bus.in_use_imm ? bus.in_imm : rs2;
    inc.s  = bus.in_aluop;
    inc.rd = bus.in_rd_addr;
`ifdef ALU_ISSUE_DIV0_EN
    inc.div0 = (inc.s == OPW'(9) || inc.s == OPW'(10))
             && inc.y == '0;
`else
    inc.div0 = 1'b0;
`endif
  end

  always_comb begin
    nxt = state;
    unique case (state)
      EMPTY: if (acc) nxt = ONE;
      ONE: begin
        if (acc && !pop)      nxt = TWO;
        else if (pop && !acc) nxt = EMPTY;
      end
      TWO:     if (pop) nxt = ONE;
      default: nxt = EMPTY;
    endcase
    if (bus.flush) nxt = EMPTY;
  end

  // in_ready is low only in TWO, so acc never fires there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      vld   <= 1'b0;
      rdy   <= 1'b0;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= nxt;
      vld   <= (nxt != EMPTY);
      rdy   <= (nxt != TWO);
      if (!bus.flush) begin
        if (state == TWO) begin
          if (pop) head <= skid;
        end else if (acc) begin
          if (state == EMPTY || pop) head <= inc;
          else                       skid <= inc;
        end
      end
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = vld;
  assign bus.alu_X       = head.x;
  assign bus.alu_Y       = head.y;
  assign bus.alu_S       = head.s;
  assign bus.out_rd_addr = head.rd;
  assign bus.out_div0    = head.div0;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases plus random traffic.
// Honours ALU_ISSUE_DIV0_EN the same way as the design.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef ALU_ISSUE_DIV0_EN
  localparam bit DIV0_ON = 1'b1;
`else
  localparam bit DIV0_ON = 1'b0;
`endif

  alu_issue_stage_if #(.XLEN(32), .OPW(4), .RAW(5)) b();

  alu_issue_stage #(.XLEN(32), .OPW(4), .RAW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  s;
    logic [4:0]  rd;
    logic        d0;
  } exp_t;

  exp_t       q[$];
  logic [4:0] popped[$];
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] a,
                                       input logic [31:0] rf);
    if (a == 0) return rf;
    if (b.fwd_mem_valid && b.fwd_mem_rd == a) return b.fwd_mem_data;
    if (b.fwd_wb_valid && b.fwd_wb_rd == a) return b.fwd_wb_data;
    return rf;
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.x  = opnd(b.in_rs1_addr, b.in_rs1_val);
    e.y  = b.in_use_imm ? b.in_imm : opnd(b.in_rs2_addr, b.in_rs2_val);
    e.s  = b.in_aluop;
    e.rd = b.in_rd_addr;
    e.d0 = DIV0_ON && (e.s == 4'd9 || e.s == 4'd10) && e.y == 0;
    return e;
  endfunction

  // Record accepted entries just after the edge decision is settled.
  always @(negedge clk) begin
    #1;
    if (rst || b.flush) q.delete();
    else if (b.in_valid && b.in_ready) q.push_back(model());
  end

  // Monitor: compare the presented head against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("out_valid", 32'(b.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(b.in_ready), 32'(q.size() < 2));
      if (b.out_valid && q.size() > 0) begin
        chk("alu_X", b.alu_X, q[0].x);
        chk("alu_Y", b.alu_Y, q[0].y);
        chk("alu_S", 32'(b.alu_S), 32'(q[0].s));
        chk("rd", 32'(b.out_rd_addr), 32'(q[0].rd));
        chk("div0", 32'(b.out_div0), 32'(q[0].d0));
        if (b.out_ready && !b.flush) begin
          popped.push_back(q[0].rd);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] r1,
                     input logic [31:0] r2, input logic [31:0] im,
                     input logic ui, input logic [4:0] a1,
                     input logic [4:0] a2, input logic [4:0] rd,
                     input logic [3:0] op);
    b.in_valid    = v;
    b.in_rs1_val  = r1;
    b.in_rs2_val  = r2;
    b.in_imm      = im;
    b.in_use_imm  = ui;
    b.in_rs1_addr = a1;
    b.in_rs2_addr = a2;
    b.in_rd_addr  = rd;
    b.in_aluop    = op;
  endtask

  task automatic fwd(input logic mv, input logic [4:0] mr,
                     input logic [31:0] md, input logic wv,
                     input logic [4:0] wr, input logic [31:0] wd);
    b.fwd_mem_valid = mv;
    b.fwd_mem_rd    = mr;
    b.fwd_mem_data  = md;
    b.fwd_wb_valid  = wv;
    b.fwd_wb_rd     = wr;
    b.fwd_wb_data   = wd;
  endtask

  bit got;
  logic [14:0] seq;

  initial begin
    b.flush = 1'b0;
    b.out_ready = 1'b1;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fwd(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_valid", 32'(b.out_valid), 0);
    chk("rst_X", b.alu_X, 0);
    chk("rst_Y", b.alu_Y, 0);
    chk("rst_S", 32'(b.alu_S), 0);
    chk("rst_rd", 32'(b.out_rd_addr), 0);
    chk("rst_div0", 32'(b.out_div0), 0);
    step();
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // basic issue
    put(1, 5, 7, 0, 0, 1, 2, 4, 4'b0010);
    step();
    b.in_valid = 1'b0;
    @(negedge clk);
    chk("basic_valid", 32'(b.out_valid), 1);
    chk("basic_X", b.alu_X, 5);
    chk("basic_Y", b.alu_Y, 7);
    chk("basic_S", 32'(b.alu_S), 2);
    step();
    @(negedge clk);
    chk("basic_gone", 32'(b.out_valid), 0);

    // forwarding priority and x0 exclusion
    step();
    put(1, 32'h1111, 32'h2222, 0, 0, 3, 3, 5, 0);
    fwd(1, 3, 32'hAAAA, 1, 3, 32'hBBBB);
    step();
    b.in_valid = 1'b0;
    @(negedge clk);
    chk("fwd_mem_X", b.alu_X, 32'hAAAA);
    chk("fwd_mem_Y", b.alu_Y, 32'hAAAA);
    step();
    put(1, 32'h1234, 32'h5678, 0, 0, 0, 3, 5, 0);
    fwd(1, 0, 32'hAAAA, 1, 0, 32'hBBBB);
    step();
    b.in_valid = 1'b0;
    @(negedge clk);
    chk("fwd_x0_X", b.alu_X, 32'h1234);
    chk("fwd_x0_Y", b.alu_Y, 32'h5678);
    step();
    put(1, 32'h1234, 0, 0, 0, 3, 0, 5, 0);
    fwd(0, 3, 32'hAAAA, 1, 3, 32'hBBBB);
    step();
    b.in_valid = 1'b0;
    fwd(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fwd_wb_X", b.alu_X, 32'hBBBB);

    // div0 flag
    step();
    put(1, 9, 9, 0, 1, 1, 1, 6, 4'b1001);
    step();
    put(1, 9, 9, 4, 1, 1, 1, 6, 4'b1001);
    @(negedge clk);
    chk("div0_imm0", 32'(b.out_div0), 32'(DIV0_ON));
    step();
    put(1, 9, 0, 4, 0, 1, 1, 6, 4'b1010);
    @(negedge clk);
    chk("div0_imm4", 32'(b.out_div0), 0);
    step();
    b.in_valid = 1'b0;
    @(negedge clk);
    chk("div0_rem", 32'(b.out_div0), 32'(DIV0_ON));

    // backpressure: A, B held, C stalled
    step();
    step();
    popped.delete();
    b.out_ready = 1'b0;
    put(1, 32'hA0, 1, 0, 0, 1, 1, 1, 0);
    step();
    put(1, 32'hB0, 2, 0, 0, 1, 1, 2, 0);
    step();
    put(1, 32'hC0, 3, 0, 0, 1, 1, 3, 0);
    @(negedge clk);
    chk("bp_in_ready", 32'(b.in_ready), 0);
    chk("bp_head", b.alu_X, 32'hA0);
    step();
    @(negedge clk);
    chk("bp_hold", b.alu_X, 32'hA0);
    step();
    b.out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = b.in_ready;
      step();
    end
    b.in_valid = 1'b0;
    chk("bp_c_accept", 32'(got), 1);
    repeat (4) step();
    seq = (popped.size() == 3) ? {popped[0], popped[1], popped[2]} : '0;
    chk("bp_count", popped.size(), 3);
    chk("bp_order", 32'(seq), 32'({5'd1, 5'd2, 5'd3}));

    // flush in TWO with incoming entry
    b.out_ready = 1'b0;
    put(1, 32'h60, 0, 0, 0, 1, 1, 6, 0);
    step();
    put(1, 32'h70, 0, 0, 0, 1, 1, 7, 0);
    step();
    put(1, 32'h80, 0, 0, 0, 1, 1, 8, 0);
    b.flush = 1'b1;
    step();
    b.flush = 1'b0;
    b.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(b.out_valid), 0);
    step();
    @(negedge clk);
    chk("flush_ready", 32'(b.in_ready), 1);
    chk("flush_valid2", 32'(b.out_valid), 0);
    step();
    put(1, 32'h90, 0, 0, 0, 1, 1, 9, 0);
    b.flush = 1'b1;
    step();
    b.flush = 1'b0;
    b.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_drop", 32'(b.out_valid), 0);

    // async reset while in TWO
    step();
    put(1, 32'h11, 0, 0, 0, 1, 1, 1, 0);
    step();
    put(1, 32'h22, 0, 0, 0, 1, 1, 2, 0);
    step();
    b.in_valid = 1'b0;
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(b.out_valid), 0);
    chk("arst_X", b.alu_X, 0);
    step();
    rst = 1'b0;
    step();
    mon_en = 1'b1;
    b.out_ready = 1'b1;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step();
      b.flush     = ($urandom_range(0, 39) == 0);
      b.out_ready = ($urandom_range(0, 9) < 6);
      put($urandom_range(0, 9) < 7, $urandom,
          ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
          ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
    end
    step();
    b.flush = 1'b0;
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
